// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings common to tx and rx, parity modes, default bit timing.
package uart_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;
  localparam state_t ST_CLNUP  = 3'd5;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  localparam int DEFAULT_CLKS_PER_BIT = 217;

  // Even mode makes the total count of ones even; odd mode inverts that.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (mode == PARITY_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake and serial-side status of the UART transmitter.
interface uart_tx_if;

  logic       in_valid;
  logic [7:0] in_byte_Tx;
  logic       out_ready;
  logic       out_serial_tx;
  logic       out_busy;
  logic       out_done;

  modport master (
    output in_valid,
    output in_byte_Tx,
    input  out_ready,
    input  out_serial_tx,
    input  out_busy,
    input  out_done
  );

  modport slave (
    input  in_valid,
    input  in_byte_Tx,
    output out_ready,
    output out_serial_tx,
    output out_busy,
    output out_done
  );

endinterface

// File: rtl/uart_bit_timer.sv
// Free-running 0..N-1 bit-period counter; bit_end flags the last clock of each bit.
// Shared between the UART transmitter and receiver.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int N = DEFAULT_CLKS_PER_BIT
) (
  input  logic in_clk,
  input  logic in_rst_n,
  input  logic clear,
  input  logic enable,
  output logic bit_end
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [CW-1:0] cnt_q;

  assign bit_end = enable && (cnt_q == CW'(N - 1));

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= bit_end ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one byte per frame, start + 8 data (LSB first) + optional parity + 1/2 stop bits.
// Line is a flop output idling high; a done pulse follows the last stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY       = PARITY_NONE,
  parameter int STOP_BITS    = 1
) (
  input logic      in_clk,
  input logic      in_rst_n,
  uart_tx_if.slave up
);

  if (CLKS_PER_BIT < 2 || PARITY < PARITY_NONE || PARITY > PARITY_ODD ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_cfg
    $error("uart_tx: illegal CLKS_PER_BIT/PARITY/STOP_BITS configuration");
  end

  state_t     state_q;
  logic [2:0] bit_idx_q;
  logic [7:0] data_q;
  logic       serial_q;
  logic       busy_q;
  logic       done_q;
  logic       bit_end;
  logic       timer_en;
  logic       timer_clr;

  assign timer_clr = (state_q == ST_IDLE);
  assign timer_en  = (state_q == ST_START) || (state_q == ST_DATA) ||
                     (state_q == ST_PARITY) || (state_q == ST_STOP);

  uart_bit_timer #(
    .N (CLKS_PER_BIT)
  ) u_bit_timer (
    .in_clk   (in_clk),
    .in_rst_n (in_rst_n),
    .clear    (timer_clr),
    .enable   (timer_en),
    .bit_end  (bit_end)
  );

  assign up.out_ready     = (state_q == ST_IDLE);
  assign up.out_serial_tx = serial_q;
  assign up.out_busy      = busy_q;
  assign up.out_done      = done_q;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q   <= ST_IDLE;
      bit_idx_q <= '0;
      data_q    <= '0;
      serial_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (up.in_valid) begin
            data_q   <= up.in_byte_Tx;
            serial_q <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            serial_q  <= data_q[0];
            bit_idx_q <= '0;
            state_q   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_idx_q == 3'd7) begin
              bit_idx_q <= '0;
              if (PARITY != PARITY_NONE) begin
                serial_q <= parity_bit(data_q, PARITY);
                state_q  <= ST_PARITY;
              end else begin
                serial_q <= 1'b1;
                state_q  <= ST_STOP;
              end
            end else begin
              serial_q  <= data_q[bit_idx_q + 3'd1];
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            serial_q  <= 1'b1;
            bit_idx_q <= '0;
            state_q   <= ST_STOP;
          end
        end
        // bit_idx_q is reused to count stop bits.
        ST_STOP: begin
          if (bit_end) begin
            if (bit_idx_q == 3'(STOP_BITS - 1)) begin
              bit_idx_q <= '0;
              done_q    <= 1'b1;
              state_q   <= ST_CLNUP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end
        ST_CLNUP: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          serial_q <= 1'b1;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four N=4 instances (8N1, even, odd, 2 stop bits) share stimulus; per-cycle line scoreboard.
module tb_uart_tx;

  localparam int N = 4;

  typedef bit bq_t[$];

  logic       in_clk = 1'b0;
  logic       in_rst_n;
  logic       vld;
  logic [7:0] byte_d;

  int n_cmp = 0;
  int n_err = 0;

  bq_t exp_n, exp_e, exp_o, exp_s;

  always #5 in_clk = ~in_clk;

  uart_tx_if if_n ();
  uart_tx_if if_e ();
  uart_tx_if if_o ();
  uart_tx_if if_s ();

  assign if_n.in_valid = vld;  assign if_n.in_byte_Tx = byte_d;
  assign if_e.in_valid = vld;  assign if_e.in_byte_Tx = byte_d;
  assign if_o.in_valid = vld;  assign if_o.in_byte_Tx = byte_d;
  assign if_s.in_valid = vld;  assign if_s.in_byte_Tx = byte_d;

  uart_tx #(.CLKS_PER_BIT(N), .PARITY(0), .STOP_BITS(1)) dut_n (.in_clk(in_clk), .in_rst_n(in_rst_n), .up(if_n.slave));
  uart_tx #(.CLKS_PER_BIT(N), .PARITY(1), .STOP_BITS(1)) dut_e (.in_clk(in_clk), .in_rst_n(in_rst_n), .up(if_e.slave));
  uart_tx #(.CLKS_PER_BIT(N), .PARITY(2), .STOP_BITS(1)) dut_o (.in_clk(in_clk), .in_rst_n(in_rst_n), .up(if_o.slave));
  uart_tx #(.CLKS_PER_BIT(N), .PARITY(0), .STOP_BITS(2)) dut_s (.in_clk(in_clk), .in_rst_n(in_rst_n), .up(if_s.slave));

  // Expected line value for every cycle of a frame, starting at the accept edge.
  function automatic bq_t model_frame(input logic [7:0] b, input int par, input int stop);
    bq_t q;
    bit  p;
    q = {};
    for (int i = 0; i < N; i++) q.push_back(1'b0);
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < N; i++) q.push_back(b[k]);
    if (par != 0) begin
      p = ^b;
      if (par == 2) p = ~p;
      for (int i = 0; i < N; i++) q.push_back(p);
    end
    for (int i = 0; i < stop * N; i++) q.push_back(1'b1);
    return q;
  endfunction

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!(if_n.out_ready && if_e.out_ready && if_o.out_ready && if_s.out_ready) && t < 300) begin
      tick();
      t++;
    end
    n_cmp++;
    if (t >= 300) begin
      n_err++;
      $display("FAIL wait_idle: ready not seen within 300 cycles (got n=%b e=%b o=%b s=%b, want all 1)",
               if_n.out_ready, if_e.out_ready, if_o.out_ready, if_s.out_ready);
    end
  endtask

  // Returns one cycle after the accept edge (cycle 0 of the frame).
  task automatic start_send(input logic [7:0] b);
    byte_d = b;
    vld    = 1'b1;
    tick();
    vld    = 1'b0;
  endtask

  task automatic test_reset();
    in_rst_n = 1'b0;
    vld      = 1'b1;
    byte_d   = 8'hA5;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp += 4;
      if (if_n.out_serial_tx !== 1'b1) begin n_err++; $display("FAIL rst_line c=%0d got %b want 1", c, if_n.out_serial_tx); end
      if (if_n.out_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready c=%0d got %b want 1", c, if_n.out_ready); end
      if (if_n.out_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy c=%0d got %b want 0", c, if_n.out_busy); end
      if (if_n.out_done !== 1'b0) begin n_err++; $display("FAIL rst_done c=%0d got %b want 0", c, if_n.out_done); end
    end
    vld      = 1'b0;
    in_rst_n = 1'b1;
    tick();
    n_cmp += 2;
    if (if_n.out_busy !== 1'b0) begin n_err++; $display("FAIL rst_no_accept busy got %b want 0", if_n.out_busy); end
    if (if_n.out_serial_tx !== 1'b1) begin n_err++; $display("FAIL rst_no_accept line got %b want 1", if_n.out_serial_tx); end
  endtask

  task automatic test_8n1();
    bit eb;
    wait_idle();
    exp_n = model_frame(8'hA5, 0, 1);
    start_send(8'hA5);
    for (int c = 0; c < 46; c++) begin
      eb = (exp_n.size() > 0) ? exp_n.pop_front() : 1'b1;
      n_cmp += 4;
      if (if_n.out_serial_tx !== eb) begin n_err++; $display("FAIL 8n1_line c=%0d got %b want %b", c, if_n.out_serial_tx, eb); end
      if (if_n.out_done !== (c == 40)) begin n_err++; $display("FAIL 8n1_done c=%0d got %b want %b", c, if_n.out_done, (c == 40)); end
      if (if_n.out_busy !== (c <= 40)) begin n_err++; $display("FAIL 8n1_busy c=%0d got %b want %b", c, if_n.out_busy, (c <= 40)); end
      if (if_n.out_ready !== (c >= 41)) begin n_err++; $display("FAIL 8n1_ready c=%0d got %b want %b", c, if_n.out_ready, (c >= 41)); end
      tick();
    end
  endtask

  task automatic test_parity();
    bit ee, eo;
    wait_idle();
    exp_e = model_frame(8'h07, 1, 1);
    exp_o = model_frame(8'h07, 2, 1);
    start_send(8'h07);
    for (int c = 0; c < 48; c++) begin
      ee = (exp_e.size() > 0) ? exp_e.pop_front() : 1'b1;
      eo = (exp_o.size() > 0) ? exp_o.pop_front() : 1'b1;
      n_cmp += 4;
      if (if_e.out_serial_tx !== ee) begin n_err++; $display("FAIL even_line c=%0d got %b want %b", c, if_e.out_serial_tx, ee); end
      if (if_o.out_serial_tx !== eo) begin n_err++; $display("FAIL odd_line c=%0d got %b want %b", c, if_o.out_serial_tx, eo); end
      if (if_e.out_done !== (c == 44)) begin n_err++; $display("FAIL even_done c=%0d got %b want %b", c, if_e.out_done, (c == 44)); end
      if (if_o.out_done !== (c == 44)) begin n_err++; $display("FAIL odd_done c=%0d got %b want %b", c, if_o.out_done, (c == 44)); end
      if (c == 37) begin
        n_cmp += 2;
        if (if_e.out_serial_tx !== 1'b1) begin n_err++; $display("FAIL even_pbit got %b want 1", if_e.out_serial_tx); end
        if (if_o.out_serial_tx !== 1'b0) begin n_err++; $display("FAIL odd_pbit got %b want 0", if_o.out_serial_tx); end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    bit eb;
    wait_idle();
    exp_n = model_frame(8'h55, 0, 1);
    exp_n.push_back(1'b1);
    exp_n.push_back(1'b1);
    exp_n = {exp_n, model_frame(8'h0F, 0, 1)};
    byte_d = 8'h55;
    vld    = 1'b1;
    tick();
    for (int c = 0; c < 86; c++) begin
      if (c == 5)  byte_d = 8'hF0;
      if (c == 20) byte_d = 8'h0F;
      eb = (exp_n.size() > 0) ? exp_n.pop_front() : 1'b1;
      n_cmp += 2;
      if (if_n.out_serial_tx !== eb) begin n_err++; $display("FAIL b2b_line c=%0d got %b want %b", c, if_n.out_serial_tx, eb); end
      if (if_n.out_done !== (c == 40 || c == 82)) begin n_err++; $display("FAIL b2b_done c=%0d got %b want %b", c, if_n.out_done, (c == 40 || c == 82)); end
      if (c == 41 || c == 42) begin
        n_cmp++;
        if (if_n.out_ready !== (c == 41)) begin n_err++; $display("FAIL b2b_ready c=%0d got %b want %b", c, if_n.out_ready, (c == 41)); end
      end
      if (c == 42) vld = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    bit eb;
    wait_idle();
    exp_n = model_frame(8'h96, 0, 1);
    start_send(8'h96);
    for (int c = 0; c < 18; c++) begin
      eb = exp_n.pop_front();
      n_cmp++;
      if (if_n.out_serial_tx !== eb) begin n_err++; $display("FAIL rmid_line c=%0d got %b want %b", c, if_n.out_serial_tx, eb); end
      if (c < 17) tick();
    end
    in_rst_n = 1'b0;
    #1;
    n_cmp += 4;
    if (if_n.out_serial_tx !== 1'b1) begin n_err++; $display("FAIL rmid_line_async got %b want 1", if_n.out_serial_tx); end
    if (if_n.out_busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy got %b want 0", if_n.out_busy); end
    if (if_n.out_ready !== 1'b1) begin n_err++; $display("FAIL rmid_ready got %b want 1", if_n.out_ready); end
    if (if_n.out_done !== 1'b0) begin n_err++; $display("FAIL rmid_done got %b want 0", if_n.out_done); end
    repeat (3) tick();
    in_rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick();
      n_cmp += 2;
      if (if_n.out_done !== 1'b0) begin n_err++; $display("FAIL rmid_no_done c=%0d got %b want 0", c, if_n.out_done); end
      if (if_n.out_serial_tx !== 1'b1) begin n_err++; $display("FAIL rmid_idle_line c=%0d got %b want 1", c, if_n.out_serial_tx); end
    end
    exp_n = model_frame(8'h3C, 0, 1);
    start_send(8'h3C);
    for (int c = 0; c < 46; c++) begin
      eb = (exp_n.size() > 0) ? exp_n.pop_front() : 1'b1;
      n_cmp += 2;
      if (if_n.out_serial_tx !== eb) begin n_err++; $display("FAIL rmid_3c_line c=%0d got %b want %b", c, if_n.out_serial_tx, eb); end
      if (if_n.out_done !== (c == 40)) begin n_err++; $display("FAIL rmid_3c_done c=%0d got %b want %b", c, if_n.out_done, (c == 40)); end
      tick();
    end
  endtask

  task automatic test_stop2();
    bit eb;
    wait_idle();
    exp_s = model_frame(8'hFF, 0, 2);
    start_send(8'hFF);
    for (int c = 0; c < 48; c++) begin
      eb = (exp_s.size() > 0) ? exp_s.pop_front() : 1'b1;
      n_cmp += 3;
      if (if_s.out_serial_tx !== eb) begin n_err++; $display("FAIL stop2_line c=%0d got %b want %b", c, if_s.out_serial_tx, eb); end
      if (if_s.out_done !== (c == 44)) begin n_err++; $display("FAIL stop2_done c=%0d got %b want %b", c, if_s.out_done, (c == 44)); end
      if (if_s.out_busy !== (c <= 44)) begin n_err++; $display("FAIL stop2_busy c=%0d got %b want %b", c, if_s.out_busy, (c <= 44)); end
      tick();
    end
  endtask

  initial begin
    in_rst_n = 1'b0;
    vld      = 1'b0;
    byte_d   = 8'h00;
    test_reset();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_reset_mid();
    test_stop2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter that serialises one byte per frame onto a single line: 8N1 by default, with optional parity and a second stop bit. It is the transmit-side counterpart of the team's UART receiver and shares its bit-timing convention: a fixed integer number of clocks per bit, with the line idling high. Upstream logic hands bytes over with a valid/ready handshake. The block raises a one-cycle done pulse after the last stop bit.

## Interface
- `CLKS_PER_BIT`, 217: clocks per serial bit; must be >= 2.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.

- `in_clk`  in  1  sole clock; all logic on its rising edge.
- `in_rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  a byte is offered on `in_byte_Tx`.
- `in_byte_Tx`  in  8  byte to send; LSB is transmitted first.
- `out_ready`  out  1  block can accept a byte (state IDLE).
- `out_serial_tx`  out  1  serial line, registered; idles high.
- `out_busy`  out  1  high from the accept edge until the CLNUP state is left.
- `out_done`  out  1  one-cycle pulse when the frame is complete.

## Operation
- States: IDLE, START_BIT, DATA_BIT, PARITY_BIT, STOP_BIT, CLNUP.
- Reset values:
  - state = IDLE, `out_serial_tx` = 1, `out_ready` = 1, `out_busy` = 0, `out_done` = 0.
  - Bit counter, bit index and shift register = 0.
- IDLE:
  - A byte is accepted on any edge where `in_valid` && `out_ready`.
  - On that edge: latch `in_byte_Tx`, clear the bit counter, drive `out_serial_tx` <= 0, set `out_busy` <= 1, go to START_BIT.
- START_BIT → DATA_BIT after `CLKS_PER_BIT` cycles. On the transition, drive bit 0.
- DATA_BIT:
  - Each bit is held for `CLKS_PER_BIT` cycles.
  - The bit index advances 0..7.
  - After bit 7, go to PARITY_BIT if `PARITY` != 0, otherwise go to STOP_BIT and drive the line high.
- PARITY_BIT:
  - Even parity: bit = XOR of the data bits.
  - Odd parity: bit = inverted XOR of the data bits.
  - Held `CLKS_PER_BIT` cycles, then go to STOP_BIT with the line high.
- STOP_BIT: line high for `STOP_BITS`*`CLKS_PER_BIT` cycles, then go to CLNUP with `out_done` <= 1.
- CLNUP:
  - Lasts one cycle; `out_done` <= 0, `out_busy` <= 0, go to IDLE.
  - Bytes are not accepted in CLNUP.
- `in_valid` and `in_byte_Tx` are ignored while `out_ready` = 0. The latched byte is immune to later input changes.
- Reset asserted mid-frame:
  - All outputs return to their reset values immediately (asynchronous reset); the line goes high at once.
  - The frame is truncated and no `out_done` pulse is produced.
- Illegal `PARITY` or `STOP_BITS` values are caught by an elaboration-time check.

## Timing
- Let N = `CLKS_PER_BIT`, P = 1 if parity is enabled (else 0), S = `STOP_BITS`, and E0 = the accept edge.
- Bit counter width is `$clog2(N)`. The counter counts 0..N-1 and wraps to 0 at each bit boundary.
- Start bit occupies cycles [E0, E0+N).
- Data bit k occupies [E0+(1+k)N, E0+(2+k)N).
- Parity bit occupies [E0+9N, E0+10N).
- Stop bits end at E0+(9+P+S)N. `out_done` is high for the cycle following that edge.
- `out_ready` rises at E0+(9+P+S)N+1. The earliest next accept edge is E0+(9+P+S)N+2.
- Minimum line-high gap between frames is S·N+2 cycles.
- `out_serial_tx` is driven directly by a flop, with no combinational path from any input.

## Structure
- The shared package `uart_pkg` holds:
  - the state encodings (3-bit, common with the receiver);
  - the `PARITY_NONE`/`PARITY_EVEN`/`PARITY_ODD` constants;
  - the default `CLKS_PER_BIT`.
- Sub-module `uart_bit_timer`:
  - parameterised by N;
  - inputs: `clear`, `enable`; output: a `bit_end` pulse when the count reaches N-1.
  - The receiver will reuse it.

## Test plan
- Reset: hold `in_rst_n` = 0 for 3 cycles with `in_valid` = 1 → `out_serial_tx` = 1, `out_ready` = 1, `out_busy` = 0, `out_done` = 0; nothing is accepted during reset.
- N = 4, 8N1, send 0xA5 → line reads 0,1,0,1,0,0,1,0,1,1, each value for 4 cycles. `out_done` pulses at E0+40+1; `out_busy` falls at E0+41.
- N = 4, send 0x07 → with even parity the parity bit = 1 during [E0+36, E0+40); with odd parity it = 0. `out_done` is at E0+44+1.
- N = 4, `in_valid` held high with 0x55 then 0x0F → the second accept occurs at E0+42. The line stays high for cycles [E0+36, E0+42). Each byte is transmitted correctly. `in_byte_Tx` changes mid-frame do not affect the line.
- N = 4, assert reset at E0+17 (during bit 3) → line high that same cycle, `out_busy` = 0, no `out_done`. After release, 0x3C is sent cleanly.
- N = 4, `STOP_BITS` = 2, send 0xFF → stop phase lasts 8 cycles and `out_done` is at E0+44+1.
